aes_round_ctrl: RTL and testbench

Sequencer for the AES-128 encryption core. It accepts one block request at a time and runs key expansion when required. It then steps the 11-way round-key select through rounds 0..NR, issuing the strobes the state register, round datapath and key-expansion unit need, and holds the result under a valid/ready handshake. It owns the select input of the round-key multiplexer; no other block drives it.

---
 rtl/aes_round_ctrl.sv | 155 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for the AES-128 encryption core.
// The block accepts one block request at a time. It runs key expansion when
// the stored keys are stale or a new key is requested. It then steps the
// round-key mux select through rounds 0..NR and holds the ciphertext under a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_valid/start_ready block request handshake (ready only in IDLE)
//   key_new                 forces key expansion, sampled on start transfer
//   abort                   synchronous abort to IDLE from any state
//   keyx_en, keyx_idx       key-expansion write strobe and round key index
//   round_sel               round-key mux select (owned by this block)
//   state_load, round_en    state register load strobes
//   final_round             round datapath skips MixColumns
//   out_valid/out_ready     ciphertext handshake
//   busy, key_valid         status
// All outputs decode from registered state only (Moore).
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       key_new,
  input  logic       abort,
  output logic       keyx_en,
  output logic [3:0] keyx_idx,
  output logic [3:0] round_sel,
  output logic       state_load,
  output logic       round_en,
  output logic       final_round,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       key_valid
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [2:0] {
    IDLE,
    KEYGEN,
    LOAD,
    ROUND,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] kcnt_q, kcnt_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       key_ok_q, key_ok_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kcnt_q   <= '0;
      rcnt_q   <= '0;
      key_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kcnt_q   <= kcnt_d;
      rcnt_q   <= rcnt_d;
      key_ok_q <= key_ok_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kcnt_d   = kcnt_q;
    rcnt_d   = rcnt_q;
    key_ok_d = key_ok_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          if (key_new || !key_ok_q) begin
            state_d  = KEYGEN;
            kcnt_d   = 4'd1;
            key_ok_d = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      KEYGEN: begin
        if (kcnt_q == NR_L) begin
          state_d  = LOAD;
          kcnt_d   = '0;
          key_ok_d = 1'b1;
        end else begin
          kcnt_d = kcnt_q + 4'd1;
        end
      end
      LOAD: begin
        state_d = ROUND;
        rcnt_d  = 4'd1;
      end
      ROUND: begin
        if (rcnt_q == NR_L) begin
          state_d = DONE;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything above, including a start transfer in IDLE.
    // Only a KEYGEN abort invalidates the keys; partial keys are never usable.
    if (abort) begin
      state_d = IDLE;
      kcnt_d  = '0;
      rcnt_d  = '0;
      if (state_q == KEYGEN) key_ok_d = 1'b0;
    end
  end

  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    keyx_en     = 1'b0;
    keyx_idx    = '0;
    round_sel   = '0;
    state_load  = 1'b0;
    round_en    = 1'b0;
    final_round = 1'b0;
    out_valid   = 1'b0;
    key_valid   = key_ok_q;
    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      KEYGEN: begin
        keyx_en   = 1'b1;
        keyx_idx  = kcnt_q;
        // Expansion unit reads the previous round key through the mux.
        round_sel = kcnt_q - 4'd1;
      end
      LOAD: state_load = 1'b1;
      ROUND: begin
        round_en    = 1'b1;
        round_sel   = rcnt_q;
        final_round = (rcnt_q == NR_L);
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed testbench for aes_round_ctrl (NR=10). Inputs change 1 ns after the
// rising edge and outputs are sampled right after, so each step() is one cycle.
module tb_aes_round_ctrl;

  localparam int unsigned NR = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       key_new = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       start_ready, keyx_en, state_load, round_en, final_round;
  logic       out_valid, busy, key_valid;
  logic [3:0] keyx_idx, round_sel;

  int tests_run = 0;
  int tests_failed = 0;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .key_new    (key_new),
    .abort      (abort),
    .keyx_en    (keyx_en),
    .keyx_idx   (keyx_idx),
    .round_sel  (round_sel),
    .state_load (state_load),
    .round_en   (round_en),
    .final_round(final_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  // {start_ready, busy, key_valid, keyx_en, state_load, round_en, final_round, out_valid}
  logic [7:0] strb;
  assign strb = {start_ready, busy, key_valid, keyx_en, state_load, round_en,
                 final_round, out_valid};

  localparam logic [7:0] S_IDLE_NOKEY = 8'b1000_0000;
  localparam logic [7:0] S_IDLE_KEY   = 8'b1010_0000;
  localparam logic [7:0] S_KEYGEN     = 8'b0101_0000;
  localparam logic [7:0] S_LOAD       = 8'b0110_1000;
  localparam logic [7:0] S_ROUND      = 8'b0110_0100;
  localparam logic [7:0] S_FINAL      = 8'b0110_0110;
  localparam logic [7:0] S_DONE       = 8'b0110_0001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks outputs of one whole block starting from IDLE. exp_kg selects
  // the expected timeline; hold is the number of DONE cycles with out_ready=0
  // during which start_valid is also raised and must be ignored.
  task automatic run_block(input logic kn, input logic exp_kg, input int unsigned hold);
    start_valid = 1'b1;
    key_new     = kn;
    chk("start_ready_idle", {7'd0, start_ready}, 8'd1);
    step();
    start_valid = 1'b0;
    key_new     = 1'b0;
    if (exp_kg) begin
      for (int unsigned i = 1; i <= NR; i++) begin
        chk("keygen_strb", strb, S_KEYGEN);
        chk("keygen_idx", {4'd0, keyx_idx}, 8'(i));
        chk("keygen_sel", {4'd0, round_sel}, 8'(i - 1));
        step();
      end
    end
    chk("load_strb", strb, S_LOAD);
    chk("load_sel", {4'd0, round_sel}, 8'd0);
    chk("load_idx", {4'd0, keyx_idx}, 8'd0);
    step();
    for (int unsigned r = 1; r <= NR; r++) begin
      chk("round_strb", strb, (r == NR) ? S_FINAL : S_ROUND);
      chk("round_sel", {4'd0, round_sel}, 8'(r));
      step();
    end
    for (int unsigned h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      chk("done_hold_strb", strb, S_DONE);
      chk("done_hold_sel", {4'd0, round_sel}, 8'd0);
      step();
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    chk("done_strb", strb, S_DONE);
    chk("done_sel", {4'd0, round_sel}, 8'd0);
    step();
    out_ready = 1'b0;
    chk("idle_after_hs", strb, S_IDLE_KEY);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, observed while rst_n is held low.
    #1;
    chk("reset_strb", strb, S_IDLE_NOKEY);
    chk("reset_sel", {4'd0, round_sel}, 8'd0);
    chk("reset_idx", {4'd0, keyx_idx}, 8'd0);
    step();
    rst_n = 1'b1;
    step();

    // New key: full expansion, 22-cycle latency.
    run_block(1'b1, 1'b1, 0);
    // Same key: no expansion, 12-cycle latency, IDLE right after handshake.
    run_block(1'b0, 1'b0, 0);

    // Reset discards keys, so key_new=0 still expands; then 5-cycle stall in DONE.
    rst_n = 1'b0;
    #1;
    chk("reset2_strb", strb, S_IDLE_NOKEY);
    step();
    rst_n = 1'b1;
    step();
    run_block(1'b0, 1'b1, 5);

    // Abort during KEYGEN at kcnt=4 invalidates keys.
    start_valid = 1'b1;
    key_new     = 1'b1;
    step();
    start_valid = 1'b0;
    key_new     = 1'b0;
    for (int unsigned i = 1; i < 4; i++) step();
    chk("abort_kg_idx", {4'd0, keyx_idx}, 8'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_kg_strb", strb, S_IDLE_NOKEY);
    run_block(1'b0, 1'b1, 0);

    // Abort during ROUND at rcnt=6 keeps keys valid.
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    for (int unsigned r = 1; r < 6; r++) step();
    chk("abort_rnd_sel", {4'd0, round_sel}, 8'd6);
    abort = 1'b1;
    step();
    chk("abort_rnd_strb", strb, S_IDLE_KEY);
    // Abort together with start in IDLE: no transfer.
    start_valid = 1'b1;
    step();
    chk("abort_start_strb", strb, S_IDLE_KEY);
    abort       = 1'b0;
    start_valid = 1'b0;
    run_block(1'b0, 1'b0, 0);

    // Asynchronous reset mid-ROUND drops all strobes immediately.
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    chk("pre_reset_round", strb, S_ROUND);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_strb", strb, S_IDLE_NOKEY);
    chk("midop_reset_sel", {4'd0, round_sel}, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", strb, S_IDLE_NOKEY);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
